// File: rtl/resampler_out_fifo.sv
// resampler_out_fifo
//   First-word-fall-through elastic buffer behind the polyphase resampler.
//   The resampler stream has no backpressure.  Samples that arrive while the
//   buffer is full, with no pop in the same cycle, are dropped, and the sticky
//   o_overflow flag records the loss.
//
// Optional feature (macro RESAMP_FIFO_DROP_CNT_EN):
//   Adds o_drop_cnt, a 16-bit saturating count of dropped samples.
//   i_clr_ovf clears the count.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   i_valid, i_data     sample strobe and signed sample from the resampler
//   o_valid, o_data     head entry is available, and its value
//   i_ready             sink accepts the head entry this cycle
//   o_level             occupancy, 0..DEPTH
//   o_afull             registered flag for o_level >= AFULL_LEVEL
//   o_overflow          sticky flag: a sample was dropped
//   i_clr_ovf           synchronous clear of the overflow status
//   o_drop_cnt          drop counter (only when the macro is defined)
module resampler_out_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_afull,
  output logic                       o_overflow,
`ifdef RESAMP_FIFO_DROP_CNT_EN
  output logic [15:0]                o_drop_cnt,
`endif
  input  logic                       i_clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         level_nxt;
  logic                  full, empty, pop, push, drop;

  // The extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign pop  = !empty && i_ready;
  // While full, a sample is taken only if the same cycle frees a slot.
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && full && !pop;

  assign o_valid = !empty;
  assign o_data  = mem[rd_ptr[AW-1:0]];
  // Modulo-2*DEPTH subtraction falls out of the PW-bit wrap.
  assign o_level = wr_ptr - rd_ptr;

  assign level_nxt = o_level + PW'(push) - PW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_afull    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= i_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_afull <= (level_nxt >= AFULL_L);
      // A drop in the same cycle as a clear wins.
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

`ifdef RESAMP_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drop_cnt <= '0;
    end else if (i_clr_ovf) begin
      o_drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_resampler_out_fifo.sv
module tb_resampler_out_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [LW-1:0] o_level;
  logic          o_afull;
  logic          o_overflow;
  logic          i_clr_ovf = 1'b0;
`ifdef RESAMP_FIFO_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  always #5 clk = ~clk;

  resampler_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_level(o_level), .o_afull(o_afull), .o_overflow(o_overflow),
`ifdef RESAMP_FIFO_DROP_CNT_EN
    .o_drop_cnt(o_drop_cnt),
`endif
    .i_clr_ovf(i_clr_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: a queue of held samples plus status.
  logic [DW-1:0] q[$];
  bit            m_ovf = 0;
  int            m_cnt = 0;
  logic [DW-1:0] last_pop = '0;

  // Applies one cycle of inputs and advances the reference model by the
  // FIFO rules, evaluated on the state before the clock edge.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
    bit m_pop, m_full, m_push, m_drop;
    i_valid = v; i_data = d; i_ready = r; i_clr_ovf = c;
    m_pop  = (q.size() > 0) && r;
    m_full = (q.size() == DEPTH);
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !m_pop;
    @(posedge clk); #1;
    if (m_pop) last_pop = q.pop_front();
    if (m_push) q.push_back(d);
    if (m_drop) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (c) m_cnt = m_drop ? 1 : 0;
    else if (m_drop && m_cnt < 65535) m_cnt++;
    i_valid = 0; i_ready = 0; i_clr_ovf = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_valid, o_data, o_level, o_afull, o_overflow} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got v=%0b d=%h lvl=%0d af=%0b ovf=%0b, want all 0",
               o_valid, o_data, o_level, o_afull, o_overflow);
    end
    rst_n = 1;
    q.delete(); m_ovf = 0; m_cnt = 0;
  endtask

  task automatic test_single();
    drive(1, 16'h1234, 0, 0);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h1234 || o_level !== LW'(1)) begin
      n_errors++;
      $display("FAIL single_push: got v=%0b d=%h lvl=%0d, want v=1 d=1234 lvl=1", o_valid, o_data, o_level);
    end
    drive(0, '0, 1, 0);
    n_checks++;
    if (o_valid !== 1'b0 || o_level !== LW'(0)) begin
      n_errors++;
      $display("FAIL single_pop: got v=%0b lvl=%0d, want v=0 lvl=0", o_valid, o_level);
    end
  endtask

  task automatic test_fill_order();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, DW'(i), 0, 0);
      n_checks++;
      if (o_level !== LW'(i) || o_afull !== (i >= AFL)) begin
        n_errors++;
        $display("FAIL fill_%0d: got lvl=%0d af=%0b, want lvl=%0d af=%0b", i, o_level, o_afull, i, i >= AFL);
      end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== DW'(i)) begin
        n_errors++;
        $display("FAIL drain_%0d: got v=%0b d=%h, want v=1 d=%h", i, o_valid, o_data, DW'(i));
      end
      drive(0, '0, 1, 0);
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_level !== LW'(0) || o_afull !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_empty: got v=%0b lvl=%0d af=%0b, want 0 0 0", o_valid, o_level, o_afull);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1, DW'($urandom), 0, 0);
    drive(1, 16'h7FFF, 0, 0);
    n_checks++;
    if (o_overflow !== 1'b1 || o_level !== LW'(DEPTH) || q.size() != DEPTH) begin
      n_errors++;
      $display("FAIL drop_at_full: got ovf=%0b lvl=%0d, want ovf=1 lvl=%0d", o_overflow, o_level, DEPTH);
    end
`ifdef RESAMP_FIFO_DROP_CNT_EN
    n_checks++;
    if (o_drop_cnt !== 16'(m_cnt)) begin
      n_errors++;
      $display("FAIL drop_cnt: got %0d, want %0d", o_drop_cnt, m_cnt);
    end
`endif
    drive(0, '0, 0, 1);
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_ovf: got ovf=%0b, want 0", o_overflow);
    end
    // Clear and drop together: the drop is what sticks.
    drive(1, 16'h0BAD, 0, 1);
    n_checks++;
    if (o_overflow !== 1'b1 || o_level !== LW'(DEPTH)) begin
      n_errors++;
      $display("FAIL clr_with_drop: got ovf=%0b lvl=%0d, want ovf=1 lvl=%0d", o_overflow, o_level, DEPTH);
    end
`ifdef RESAMP_FIFO_DROP_CNT_EN
    n_checks++;
    if (o_drop_cnt !== 16'(m_cnt)) begin
      n_errors++;
      $display("FAIL clr_with_drop_cnt: got %0d, want %0d", o_drop_cnt, m_cnt);
    end
`endif
    drive(0, '0, 0, 1);
  endtask

  task automatic test_full_pop();
    drive(1, 16'h8000, 1, 0);
    n_checks++;
    if (o_level !== LW'(DEPTH) || o_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%0b, want lvl=%0d ovf=0", o_level, o_overflow, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== q[0]) begin
        n_errors++;
        $display("FAIL full_drain_%0d: got v=%0b d=%h, want v=1 d=%h", i, o_valid, o_data, q[0]);
      end
      drive(0, '0, 1, 0);
    end
    n_checks++;
    if (last_pop !== 16'h8000 || o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL full_last: got last=%h v=%0b, want last=8000 v=0", last_pop, o_valid);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] smp;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      smp = DW'($urandom);
      drive((cyc % 3) != 2, smp, $urandom_range(0, 99) < 80, 0);
      n_checks++;
      if (o_valid !== (q.size() > 0) || o_level !== LW'(q.size()) ||
          (q.size() > 0 && o_data !== q[0]) || o_afull !== (q.size() >= AFL) ||
          o_overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL stream_c%0d: got v=%0b d=%h lvl=%0d af=%0b ovf=%0b, want v=%0b d=%h lvl=%0d ovf=%0b",
                 cyc, o_valid, o_data, o_level, o_afull, o_overflow,
                 q.size() > 0, (q.size() > 0) ? q[0] : '0, q.size(), m_ovf);
      end
    end
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_ovf: got %0b, want 0", o_overflow);
    end
    while (q.size() > 0) drive(0, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) drive(1, DW'($urandom), 0, 0);
    n_checks++;
    if (o_level !== LW'(7)) begin
      n_errors++;
      $display("FAIL pre_reset_level: got %0d, want 7", o_level);
    end
    i_valid = 1; i_data = 16'hDEAD;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({o_valid, o_data, o_level, o_afull, o_overflow} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%0b d=%h lvl=%0d af=%0b ovf=%0b, want all 0",
               o_valid, o_data, o_level, o_afull, o_overflow);
    end
    i_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    q.delete(); m_ovf = 0; m_cnt = 0;
    drive(1, 16'h5A5A, 0, 0);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h5A5A || o_level !== LW'(1)) begin
      n_errors++;
      $display("FAIL post_reset_push: got v=%0b d=%h lvl=%0d, want v=1 d=5a5a lvl=1", o_valid, o_data, o_level);
    end
    drive(0, '0, 1, 0);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_only: got v=%0b, want 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_overflow();
    test_full_pop();
    test_streaming();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
